// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out frame capture block:
// controller state encoding and the default frame width.
package sipo_pkg;

  localparam int SIPO_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } sipo_state_e;

endpackage

// File: rtl/shift_reg_sipo.sv
// MSB-first serial-in shift register; holds its contents whenever en is low.
module shift_reg_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             s_dout
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (en) begin
      r_sr <= {r_sr[WIDTH-2:0], din};
    end
  end

  assign q      = r_sr;
  assign s_dout = r_sr[WIDTH-1];

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame capture controller: shifts WIDTH serial bits after a start request,
// presents the word with a valid/ready handshake and flags ignored starts.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  output logic             s_dout,
  output logic             busy,
  output logic             overrun
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sipo_state_e      r_state;
  sipo_state_e      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p_dout;
  logic             r_p_valid;
  logic             r_overrun;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;
  logic             w_en;
  logic             w_last;
  logic             w_accept;
  logic             w_unused_q_msb;

  shift_reg_sipo #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_en),
    .din    (din),
    .q      (w_q),
    .s_dout (s_dout)
  );

  // The captured word includes the bit arriving on the load edge itself,
  // so it is formed from the register contents plus the live din.
  assign w_word         = {w_q[WIDTH-2:0], din};
  assign w_unused_q_msb = w_q[WIDTH-1];

  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
  assign w_accept = (r_state == ST_HOLD) && r_p_valid && p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)    w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last)   w_next_state = ST_HOLD;
      ST_HOLD:  if (w_accept) w_next_state = start ? ST_SHIFT : ST_IDLE;
      default:                w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    w_en = 1'b0;
    if (r_state == ST_SHIFT) begin
      busy = 1'b1;
      w_en = 1'b1;
    end
  end

  // Counter runs only in SHIFT and is parked at zero elsewhere, so every
  // entry into SHIFT starts from a clean count without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == ST_SHIFT) && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_dout  <= '0;
      r_p_valid <= 1'b0;
    end else if (w_last) begin
      r_p_dout  <= w_word;
      r_p_valid <= 1'b1;
    end else if (w_accept) begin
      r_p_valid <= 1'b0;
    end
  end

  // Sticky: a start that arrives while a frame is still unconsumed is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if ((r_state == ST_HOLD) && start && !p_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign p_dout  = r_p_dout;
  assign p_valid = r_p_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: frame capture, handshake stalls,
// back-to-back restart, overrun flag, mid-frame reset and start during SHIFT.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       din;
  logic       p_ready;
  logic [7:0] p_dout;
  logic       p_valid;
  logic       s_dout;
  logic       busy;
  logic       overrun;

  int n_tests;
  int n_fail;

  sipo_frame_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .din     (din),
    .p_ready (p_ready),
    .p_dout  (p_dout),
    .p_valid (p_valid),
    .s_dout  (s_dout),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start edge followed by eight MSB-first data edges; optionally toggles
  // start while shifting. Checks that valid appears only on the last edge.
  task automatic send_frame(input logic [7:0] w, input bit toggle_start);
    start = 1'b1;
    tick();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      din = w[i];
      if (toggle_start) start = ~start;
      tick();
      if (i == 1) check("valid_before_last", {31'd0, p_valid}, 32'd0);
    end
    start = 1'b0;
    din   = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    din     = 1'b0;
    p_ready = 1'b0;

    tick();
    tick();
    check("rst_p_dout",  {24'd0, p_dout},  32'h0);
    check("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_s_dout",  {31'd0, s_dout},  32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // First frame: 1,0,1,1,0,0,1,0 -> 0xB2, start honoured on first edge.
    rst_n = 1'b1;
    send_frame(8'hB2, 1'b0);
    check("f1_p_dout",  {24'd0, p_dout},  32'hB2);
    check("f1_p_valid", {31'd0, p_valid}, 32'd1);
    check("f1_busy",    {31'd0, busy},    32'd0);
    check("f1_s_dout",  {31'd0, s_dout},  32'd1);

    // Consumer stalls for five cycles; word, valid and s_dout stay frozen.
    for (int i = 0; i < 5; i++) begin
      din = ~din;
      tick();
      check("stall_p_dout",  {24'd0, p_dout},  32'hB2);
      check("stall_p_valid", {31'd0, p_valid}, 32'd1);
      check("stall_s_dout",  {31'd0, s_dout},  32'd1);
    end
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("acc_p_valid", {31'd0, p_valid}, 32'd0);
    check("acc_busy",    {31'd0, busy},    32'd0);
    tick();
    check("idle_busy",   {31'd0, busy},    32'd0);
    check("idle_p_dout", {24'd0, p_dout},  32'hB2);

    // Accept and restart on the same edge, then an all-ones frame.
    send_frame(8'h3C, 1'b0);
    check("f2_p_dout", {24'd0, p_dout}, 32'h3C);
    start   = 1'b1;
    p_ready = 1'b1;
    tick();
    start   = 1'b0;
    p_ready = 1'b0;
    check("b2b_p_valid", {31'd0, p_valid}, 32'd0);
    check("b2b_busy",    {31'd0, busy},    32'd1);
    din = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    din = 1'b0;
    check("ff_p_dout",  {24'd0, p_dout},  32'hFF);
    check("ff_p_valid", {31'd0, p_valid}, 32'd1);
    check("ff_overrun", {31'd0, overrun}, 32'd0);

    // Start while the frame is still pending and unaccepted.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ovr_flag",    {31'd0, overrun}, 32'd1);
    check("ovr_p_dout",  {24'd0, p_dout},  32'hFF);
    check("ovr_p_valid", {31'd0, p_valid}, 32'd1);
    check("ovr_busy",    {31'd0, busy},    32'd0);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    send_frame(8'h81, 1'b0);
    check("ovr_next_p_dout", {24'd0, p_dout},  32'h81);
    check("ovr_sticky",      {31'd0, overrun}, 32'd1);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;

    // Toggling start during SHIFT must not restart the frame.
    send_frame(8'h6D, 1'b1);
    check("tog_p_dout",  {24'd0, p_dout},  32'h6D);
    check("tog_p_valid", {31'd0, p_valid}, 32'd1);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;

    // Reset in the middle of a frame clears everything asynchronously.
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_p_dout",  {24'd0, p_dout},  32'h0);
    check("arst_p_valid", {31'd0, p_valid}, 32'd0);
    check("arst_busy",    {31'd0, busy},    32'd0);
    check("arst_s_dout",  {31'd0, s_dout},  32'd0);
    check("arst_overrun", {31'd0, overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b0);
    check("fresh_p_dout",  {24'd0, p_dout},  32'h5A);
    check("fresh_p_valid", {31'd0, p_valid}, 32'd1);
    check("fresh_overrun", {31'd0, overrun}, 32'd0);
    check("fresh_s_dout",  {31'd0, s_dout},  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the frame length in bits and the parallel word width.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to capture one frame; sampled only in IDLE, or in HOLD on the handshake edge.
REQ-005 Port din, input, 1 bit: serial data, MSB first.
REQ-006 Port p_ready, input, 1 bit: the consumer accepts p_dout.
REQ-007 Port p_dout, output, WIDTH bits: captured parallel word, registered, stable while p_valid=1.
REQ-008 Port p_valid, output, 1 bit: p_dout holds a complete frame.
REQ-009 Port s_dout, output, 1 bit: serial pass-through, equal to the shift-register MSB.
REQ-010 Port busy, output, 1 bit: high in SHIFT.
REQ-011 Port overrun, output, 1 bit: sticky error flag.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-013 IDLE -> SHIFT on an edge with start=1; bit counter cleared to 0; din is not captured on this edge.
REQ-014 In SHIFT, each edge SHALL shift sr <= {sr[WIDTH-2:0], din} and increment the counter.
REQ-015 The edge with counter=WIDTH-1 SHALL load p_dout with the fully shifted word, set p_valid=1 and go to HOLD; p_valid is high after edge WIDTH+1, counting the start edge as edge 1.
REQ-016 In HOLD, an edge with p_valid=1 and p_ready=1 SHALL clear p_valid and go to IDLE, or to SHIFT (counter=0) if start=1 on the same edge.
REQ-017 In HOLD, start=1 with p_ready=0 SHALL set overrun=1, be otherwise ignored, and leave p_dout and p_valid unchanged.
REQ-018 In SHIFT, start is ignored; din is sampled every edge regardless of p_ready.
REQ-019 overrun SHALL clear only on reset.
REQ-020 The counter width SHALL be clog2(WIDTH); no wrap occurs, because SHIFT exits at WIDTH-1.
REQ-021 The shift register SHALL hold its value in IDLE and HOLD, so s_dout is frozen in those states.
REQ-022 p_dout SHALL change only on the REQ-015 load edge.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, counter=0, sr=0, p_dout=0, p_valid=0, busy=0, s_dout=0 and overrun=0.
REQ-024 Reset asserted mid-SHIFT or mid-HOLD SHALL discard the partial or pending frame.
REQ-025 The first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-026 The state encoding (IDLE, SHIFT, HOLD) and the WIDTH default SHALL live in a shared package, sipo_pkg.
REQ-027 The shift register SHALL be one sub-module, shift_reg_sipo, with ports clk, rst_n, en, din, q[WIDTH-1:0] and s_dout.
REQ-028 The controller SHALL drive en=1 only in SHIFT.

Verification
REQ-029 Reset, then start pulse, then din=1,0,1,1,0,0,1,0 on 8 edges -> p_valid=1 and p_dout=8'hB2 after edge 9; busy=0.
REQ-030 Hold p_ready=0 for 5 cycles with a frame pending -> p_dout stays 8'hB2 and p_valid stays 1; raise p_ready -> p_valid=0 next edge, state IDLE.
REQ-031 Assert start and p_ready together in HOLD, then din=all 1s -> second frame p_dout=8'hFF, overrun stays 0.
REQ-032 Assert start in HOLD with p_ready=0 -> overrun=1 and p_dout unchanged; overrun stays 1 through the next frame until reset.
REQ-033 Assert rst_n=0 after 4 shift edges -> all outputs 0 immediately; a new start captures a complete fresh frame of 8'h5A.
REQ-034 Toggle start during SHIFT -> no restart; the frame completes on the 8th shift edge.
